// File: rtl/spart_rx.sv
// SPART receive stage: 16x-oversampled 8N1 deframer with rda/rd_ack handshake.
// Optional build macro SPART_RX_AUTOCLR_EN turns rda into a one-cycle pulse per good byte.
module spart_rx #(
    parameter int unsigned BAUD_DIV   = 326,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic       rda,
    output logic [7:0] databus,
    output logic       framing_err,
    output logic       overrun
);

    localparam int unsigned DIV_W = $clog2(BAUD_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BAUD_DIV - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitIdle = 3'd4;

    logic             rxd_meta_q, rxd_s_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       state_q, state_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rda_q, rda_d;
    logic [7:0]       databus_q, databus_d;
    logic             framing_err_q, framing_err_d;
    logic             overrun_q, overrun_d;
    logic             tick, byte_done, frame_bad;

    assign tick = (div_cnt_q == DIV_MAX);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        // Held at zero while idle so the tick phase realigns on every start edge
        if (state_q == StIdle || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (!rxd_s_q) begin
                    state_d    = StStart;
                    tick_cnt_d = 4'd0;
                end
            end
            StStart: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == MID_TICK) begin
                        if (!rxd_s_q) begin
                            state_d    = StData;
                            tick_cnt_d = 4'd0;
                            bit_idx_d  = 3'd0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StData: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == LAST_TICK) begin
                        shift_d   = {rxd_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == LAST_TICK) begin
                        if (rxd_s_q) begin
                            byte_done = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            frame_bad = 1'b1;
                            state_d   = StWaitIdle;
                        end
                    end
                end
            end
            StWaitIdle: begin
                if (rxd_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rda_d         = rda_q;
        databus_d     = databus_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;
`ifdef SPART_RX_AUTOCLR_EN
        rda_d     = byte_done;
        overrun_d = 1'b0;
        if (rd_ack) begin
            framing_err_d = 1'b0;
        end
`else
        if (rd_ack) begin
            rda_d         = 1'b0;
            overrun_d     = 1'b0;
            framing_err_d = 1'b0;
        end
        // A completing byte beats a simultaneous acknowledge
        if (byte_done) begin
            rda_d     = 1'b1;
            overrun_d = overrun_d | (rda_q & ~rd_ack);
        end
`endif
        if (byte_done) begin
            databus_d = shift_q;
        end
        if (frame_bad) begin
            framing_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q    <= 1'b1;
            rxd_s_q       <= 1'b1;
            div_cnt_q     <= '0;
            state_q       <= StIdle;
            tick_cnt_q    <= 4'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rda_q         <= 1'b0;
            databus_q     <= 8'h00;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rxd_meta_q    <= rxd;
            rxd_s_q       <= rxd_meta_q;
            div_cnt_q     <= div_cnt_d;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rda_q         <= rda_d;
            databus_q     <= databus_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rda         = rda_q;
    assign databus     = databus_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: serial frames in, scoreboard of expected bytes and arrival cycles out.
module tb_spart_rx;

    localparam int BAUD_DIV   = 4;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = OVERSAMPLE * BAUD_DIV;
    // Falling edge to rda: 2 sync flops + IDLE exit, then 9.5 bit periods of ticks
    localparam int LAT        = 3 + (OVERSAMPLE / 2 + 9 * OVERSAMPLE) * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_ack = 1'b0;
    logic       rda;
    logic [7:0] databus;
    logic       framing_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    spart_rx #(.BAUD_DIV(BAUD_DIV), .OVERSAMPLE(OVERSAMPLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rd_ack      (rd_ack),
        .rda         (rda),
        .databus     (databus),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first ncyc clocks of an 8N1 frame, then return the line to idle if cut short
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit expect_byte,
                              input int ncyc);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        if (expect_byte) exp_q.push_back('{data: d, due: cyc + LAT});
        for (int c = 0; c < ncyc; c++) begin
            rxd = frame[c / BIT_CLKS];
            step(1);
        end
        if (ncyc < 10 * BIT_CLKS) rxd = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1, 1'b1, 10 * BIT_CLKS);
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
    endtask

    // Monitor: a new byte is presented when rda rises or databus changes under a held rda
    logic       prev_rda = 1'b0;
    logic [7:0] prev_db  = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (rda && (!prev_rda || databus != prev_db)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", databus, -1);
                end else begin
                    check("sb_data", databus, exp_q[0].data);
                    check("sb_cycle", cyc, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].due + 2) begin
                check("sb_missing_byte", 0, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
        prev_rda = rda;
        prev_db  = databus;
    end

    initial begin
        logic [7:0] d;
        int start;

        step(3);
        check("reset_rda", rda, 0);
        check("reset_databus", databus, 8'h00);
        check("reset_framing", framing_err, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
        step(5);

        // Basic byte and acknowledge
        send_byte(8'h77);
        check("t1_rda", rda, 1);
        check("t1_databus", databus, 8'h77);
        ack();
        check("t1_rda_cleared", rda, 0);

        // Start-bit glitch is rejected
        rxd = 1'b0;
        step(20);
        rxd = 1'b1;
        step(100);
        check("t2_glitch_rda", rda, 0);
        check("t2_glitch_framing", framing_err, 0);
        send_byte(8'h4A);
        check("t2_databus", databus, 8'h4A);
        check("t2_rda", rda, 1);
        ack();

        // Bad stop bit, then a held-low line must not retrigger
        send_frame(8'h61, 1'b0, 1'b0, 10 * BIT_CLKS);
        step(300);
        check("t3_framing", framing_err, 1);
        check("t3_rda", rda, 0);
        check("t3_databus_held", databus, 8'h4A);
        rxd = 1'b1;
        step(20);
        send_byte(8'h53);
        check("t3_databus", databus, 8'h53);
        check("t3_rda", rda, 1);
        check("t3_framing_sticky", framing_err, 1);
        ack();
        check("t3_framing_cleared", framing_err, 0);
        check("t3_rda_cleared", rda, 0);

        // Overrun
        send_byte(8'h57);
        send_byte(8'h44);
        check("t4_databus", databus, 8'h44);
        check("t4_rda", rda, 1);
        check("t4_overrun", overrun, 1);
        ack();
        check("t4_rda_cleared", rda, 0);
        check("t4_overrun_cleared", overrun, 0);

        // rd_ack on the exact completion cycle of the second byte
        send_byte(8'($urandom_range(0, 255)));
        start = cyc;
        fork
            send_byte(8'h64);
            begin
                step(LAT - 1);
                rd_ack = 1'b1;
                step(1);
                rd_ack = 1'b0;
            end
        join
        check("t5_rda", rda, 1);
        check("t5_databus", databus, 8'h64);
        check("t5_overrun", overrun, 0);
        check("t5_elapsed", cyc - start, 10 * BIT_CLKS);
        ack();

        // Reset in the middle of data bit 4 aborts the frame
        send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 5 * BIT_CLKS + BIT_CLKS / 2);
        rst = 1'b1;
        step(1);
        check("t6_rst_rda", rda, 0);
        check("t6_rst_databus", databus, 8'h00);
        check("t6_rst_framing", framing_err, 0);
        check("t6_rst_overrun", overrun, 0);
        rst = 1'b0;
        step(5);
        send_byte(8'h41);
        check("t6_databus", databus, 8'h41);
        check("t6_rda", rda, 1);
        step(1);
        check("t6_rda_level", rda, 1);
        ack();

        // Randomized bytes with random idle gaps
        repeat (8) begin
            d = 8'($urandom_range(0, 255));
            send_byte(d);
            step($urandom_range(1, 40));
            check("rand_rda", rda, 1);
            check("rand_databus", databus, d);
            ack();
            check("rand_rda_cleared", rda, 0);
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step(1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Serial receive stage of the SPART. Samples the asynchronous RXD line with 16x oversampling and deframes 8N1 characters (LSB first).
- Presents each received byte on databus and flags it with rda. Feeds spart_cpu_interface, which rising-edge-detects rda and decodes databus into key masks.
- Also reports framing and overrun errors.

Parameters:
- BAUD_DIV, 326: clocks per oversample tick. 50 MHz / (9600 x 16) rounded. Must be >= 2.
- OVERSAMPLE, 16: ticks per bit period. Fixed at 16; the mid-bit sample is at tick 8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rxd  input  1  asynchronous serial line; idle high
- rd_ack  input  1  one-cycle strobe from consumer; byte taken, clear flags
- rda  output  1  receive data available
- databus  output  8  last received byte
- framing_err  output  1  sticky; stop bit sampled low
- overrun  output  1  sticky; byte completed while rda still set

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: rda=0, databus=8'h00, framing_err=0, overrun=0, state=IDLE, synchronizer flops=1, all counters=0.
  - rst mid-frame aborts the frame; no partial byte is ever exposed.
- Input synchronization:
  - 2-flop synchronizer on rxd gives rxd_s. All decisions use rxd_s, which adds 2 cycles of latency.
- Tick generator:
  - div_cnt counts 0..BAUD_DIV-1; tick=1 when div_cnt==BAUD_DIV-1, then wraps to 0.
  - div_cnt is forced to 0 in IDLE, so it realigns on every start edge.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE. Counters: tick_cnt (4b), bit_idx (3b), shift (8b).
  - IDLE: rxd_s==0 -> START with tick_cnt=0.
  - START: on the 8th tick (mid start bit), if rxd_s==0 -> DATA with tick_cnt=0, bit_idx=0. Otherwise it was a glitch -> IDLE with no flags.
  - DATA: on every 16th tick, shift = {rxd_s, shift[7:1]}. After bit_idx==7 -> STOP.
  - STOP: on the 16th tick, sample rxd_s.
    - If 1: databus<=shift and rda<=1 on the next clock, then go IDLE.
    - If 0: framing_err<=1, databus and rda unchanged, then go WAIT_IDLE.
  - WAIT_IDLE: stays until rxd_s==1, then goes IDLE. This prevents a held-low/break line from retriggering.
- Latency: rda rises exactly 1 clock after the stop-bit sampling tick, which is about 9.5 bit periods + 3 clocks after the rxd falling edge.
- rda and rd_ack handshake:
  - rda stays high until rd_ack. rd_ack clears rda, overrun and framing_err on the next clock.
  - rd_ack while rda=0 only clears the error flags.
- Simultaneous events:
  - Byte completion in the same cycle as rd_ack: the new byte wins. rda stays 1, databus updates, overrun stays 0, framing_err clears.
  - Byte completion while rda=1 with no rd_ack: databus is overwritten with the newer byte, overrun<=1, rda stays 1.
- Because rda is a level, the downstream edge detector sees no new edge until rd_ack has cleared rda.

Optional Feature:
- Macro: SPART_RX_AUTOCLR_EN.
- Defined:
  - rda is a single-cycle pulse on each good byte, so the downstream edge detector sees every byte without acknowledgment.
  - rd_ack clears framing_err only; overrun is tied to 0.
  - databus still holds its value until the next byte.
- Undefined: level/acknowledge behaviour as specified above.

Test Plan:
1. BAUD_DIV=4 (64-clock bits); send 8'h77 -> databus==8'h77, rda rises 1 clk after the stop sample tick; pulse rd_ack -> rda==0 next clk.
2. rxd low for 5 ticks (20 clks) then high -> no rda, FSM back to IDLE; then send 8'h4A -> databus==8'h4A, rda==1.
3. Send 8'h61 with stop bit 0, then hold rxd low 300 clks -> framing_err==1, rda==0, databus unchanged, no retrigger; release rxd and send 8'h53 -> databus==8'h53, rda==1; rd_ack clears framing_err.
4. Send 8'h57 then 8'h44 without rd_ack -> databus==8'h44, rda==1, overrun==1; rd_ack -> rda==0, overrun==0.
5. Assert rd_ack on the exact cycle the second byte 8'h64 completes -> rda stays 1, databus==8'h64, overrun==0.
6. Assert rst during DATA bit 4 -> all outputs at reset values next clk; then send 8'h41 -> databus==8'h41 (with SPART_RX_AUTOCLR_EN: rda high exactly 1 clk).
